// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader:
// FSM state encoding and stream geometry.
package inst_mem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RECV,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_e;

  // States in which the loader offers in_ready
  function automatic logic takes_byte(state_e s);
    return (s == S_HDR) || (s == S_RECV) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction RAM write port bundle.
// master = loader side, slave = byte source / RAM side.
interface inst_mem_loader_if #(
  parameter int ADDR = 6,
  parameter int SIZE = 32
) ();

  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic            mem_we;
  logic [ADDR-1:0] mem_addr;
  logic [SIZE-1:0] mem_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/inst_mem_loader_byte_assembler.sv
// Collects stream bytes MSB first into a 32-bit word.
// Only three bytes are stored; the fourth is merged on the fly.
module inst_mem_loader_byte_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_nxt,
  output logic        word_full
);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;

  // Shift register and byte index next-state
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clear) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[15:0], byte_i};
      idx_d = idx_q + 2'd1;
    end
  end

  // Word that results if byte_i is the last byte of it
  assign word_nxt  = {sr_q, byte_i};
  assign word_full = (idx_q == 2'(BYTES_PER_WORD - 1));

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte-streamed program into instruction RAM and
// holds the CPU in reset until a load ends with a good checksum.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR  = 6,
  parameter int SIZE  = 32,
  parameter int DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  inst_mem_loader_if.master   bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                err
);

  state_e          state_q, state_d;
  logic [ADDR:0]   n_q, n_d;
  logic [ADDR:0]   cnt_q, cnt_d;
  logic [7:0]      acc_q, acc_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            mem_we_q, mem_we_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            load_done_q, load_done_d;

  logic            accept;
  logic            asm_clear;
  logic            asm_shift;
  logic [31:0]     word_nxt;
  logic            word_full;

  assign accept = bus.in_valid & in_ready_q;

  inst_mem_loader_byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .byte_i    (bus.in_data),
    .word_nxt  (word_nxt),
    .word_full (word_full)
  );

  // Load FSM; all outputs are registered from the next state
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    asm_clear   = 1'b0;
    asm_shift   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          acc_d     = '0;
          cnt_d     = '0;
          asm_clear = 1'b1;
          if (bus.in_data == 8'd0) begin
            state_d = S_CHK;
          end else if (int'(bus.in_data) > DEPTH) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            n_d     = (ADDR+1)'(bus.in_data);
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          acc_d     = acc_q ^ bus.in_data;
          asm_shift = 1'b1;
          if (word_full) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[ADDR-1:0];
            mem_wdata_d = SIZE'(word_nxt);
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == n_q) ? S_CHK : S_RECV;
      end
      S_CHK: begin
        if (accept) begin
          if (bus.in_data != acc_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = S_HDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = takes_byte(state_d);
    load_done_d = (state_d == S_DONE);
    cpu_hold_d  = !((state_d == S_DONE) && !err_d);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign err           = err_q;

endmodule
